// File: rtl/param_serializer.sv
// -----------------------------------------------------------------------------
// param_serializer
//
// Parallel-to-serial converter for the self-test datapath. Takes DATA_W-bit
// words over a valid/ready handshake and shifts them out one bit per t_clk,
// with a qualifying valid strobe and a frame-start marker. Back-to-back words
// stream with no idle gap: the next word is accepted during the final cycle of
// the current frame.
//
// Parameters:
//   DATA_W     parallel word width, 2..64
//   LSB_FIRST  0 = MSB transmitted first, 1 = LSB transmitted first
//
// Optional build macro:
//   SER_PARITY_EN  when defined, each frame carries one extra trailing cycle
//                  holding the even parity of the captured word. The accept
//                  window for the next word moves to that parity cycle.
//
// Ports:
//   t_clk        clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   din          parallel word to transmit
//   din_valid    din holds a word to transmit
//   din_ready    block can accept din this cycle
//   sout         serial data bit
//   sout_valid   sout carries a frame bit this cycle
//   frame_start  high on the first bit of each frame
//   busy         a frame is in progress
//
// State table:
//   state  | meaning
//   IDLE   | no frame in flight, ready for a word
//   SHIFT  | data bits on sout, cnt = index of the bit being shown
//   PARITY | parity bit on sout (SER_PARITY_EN builds only)
// -----------------------------------------------------------------------------
module param_serializer #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              t_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
`ifdef SER_PARITY_EN
    logic              parity_r;
`endif

    logic              last_bit;
    logic              ready_int;
    logic              accept;
    logic              data_bit;
    logic              sout_int;
    logic [DATA_W-1:0] shreg_next;

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

`ifdef SER_PARITY_EN
    // Last data bit hands over to the parity cycle, which owns the accept slot.
    assign ready_int = (state == IDLE) || (state == PARITY);
`else
    assign ready_int = (state == IDLE) || last_bit;
`endif

    assign accept = din_valid && ready_int;

    // Shift toward the output end, zero-filling behind.
    always_comb begin
        shreg_next = '0;
        data_bit   = 1'b0;
        if (LSB_FIRST) begin
            shreg_next = shreg >> 1;
            data_bit   = shreg[0];
        end else begin
            shreg_next = shreg << 1;
            data_bit   = shreg[DATA_W-1];
        end
    end

    always_comb begin
        sout_int = 1'b0;
        case (state)
            SHIFT:   sout_int = data_bit;
`ifdef SER_PARITY_EN
            PARITY:  sout_int = parity_r;
`endif
            default: sout_int = 1'b0;
        endcase
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
`ifdef SER_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else if (accept) begin
            // Covers both the IDLE start and the streaming reload at frame end.
            state    <= SHIFT;
            shreg    <= din;
            cnt      <= '0;
`ifdef SER_PARITY_EN
            parity_r <= ^din;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                SHIFT: begin
                    shreg <= shreg_next;
                    if (cnt == CNT_LAST) begin
                        // Explicit terminal compare: DATA_W need not be a power of two.
                        cnt   <= '0;
`ifdef SER_PARITY_EN
                        state <= PARITY;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef SER_PARITY_EN
                PARITY: begin
                    state <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low for as long as rst_n is asserted, not just after
    // the flops clear, so din_ready cannot glitch high during reset.
    assign din_ready   = rst_n & ready_int;
    assign sout        = rst_n & sout_int;
    assign sout_valid  = rst_n & (state != IDLE);
    assign busy        = rst_n & (state != IDLE);
    assign frame_start = rst_n & (state == SHIFT) & (cnt == '0);

endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
- Parametrised parallel-to-serial converter for the self-test datapath.
- Accepts DATA_W-bit words over a valid/ready handshake and shifts them out one bit per t_clk, with a qualifying valid strobe and a frame-start marker.
- Bit order is selectable. Back-to-back words stream with no idle gap.
- Sits between the pattern/data source and the serial test link.

Parameters:
- DATA_W, 8, parallel word width in bits; legal range 2..64.
- LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB transmitted first.

Ports:
- t_clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  DATA_W  parallel word to transmit
- din_valid  input  1  din holds a word to transmit
- din_ready  output  1  block can accept din this cycle
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a frame bit this cycle
- frame_start  output  1  high on the first bit of each frame
- busy  output  1  a frame is in progress

Behaviour:
- Reset and reset values:
  - All state resets asynchronously: state = IDLE, shift register = 0, bit counter = 0.
  - While rst_n is low, sout, sout_valid, frame_start, busy and din_ready are all forced to 0 combinationally.
- Accept:
  - A word is accepted on a rising edge where din_valid && din_ready.
  - din is captured into the shift register at that edge.
- States:
  - IDLE: din_ready = 1, sout = 0, sout_valid = 0, busy = 0.
  - IDLE -> SHIFT on accept.
  - SHIFT: sout_valid = 1, busy = 1.
  - sout = shreg[DATA_W-1] when LSB_FIRST = 0, shreg[0] when LSB_FIRST = 1.
  - Each edge shifts toward the output end, zero-filling, and increments the bit counter.
- Frame length and counter:
  - A frame is exactly DATA_W consecutive sout_valid cycles.
  - The counter is $clog2(DATA_W) bits wide and runs 0..DATA_W-1. It must not rely on natural wrap.
- Latency: the first bit appears on sout in the cycle immediately after the accept edge.
- frame_start: high only when the counter is 0 in SHIFT.
- Last bit (counter == DATA_W-1):
  - din_ready = 1 in this cycle.
  - If din_valid is also high, the new word loads and the counter returns to 0. The next cycle is the new frame's first bit, with no gap (streaming).
  - Otherwise SHIFT -> IDLE.
- Handshake rules:
  - din_ready is combinational from state/counter and is never high in the middle of a frame.
  - din and din_valid are ignored when din_ready = 0.
  - The producer must hold din stable while din_valid && !din_ready.
- Reset mid-frame:
  - The frame is aborted immediately.
  - After release the block is in IDLE, and no residual bits of the aborted word are ever emitted.
- din_valid high across reset release: the word is accepted on the first edge with rst_n high. sout_valid rises on the following cycle.

Optional Feature:
- Macro: SER_PARITY_EN
- Defined:
  - After the DATA_W data bits, one extra cycle emits an even parity bit (XOR of all captured din bits), with sout_valid = 1 and frame_start = 0.
  - Frame length becomes DATA_W+1.
  - din_ready and the streaming accept move to the parity cycle.
  - The parity is computed at the accept edge and held in a register.
- Undefined: no parity cycle or register. Frame length is DATA_W.

Test Plan:
- DATA_W=8, LSB_FIRST=0, single 0xA5 -> sout = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; frame_start only on cycle 1; sout_valid low and din_ready high on cycle 9.
- Back-to-back 0xA5 then 0x3C, din_valid held high -> 16 contiguous sout_valid cycles with bits 10100101 00111100; frame_start on cycles 1 and 9; din_ready high only on cycles 0 and 8.
- LSB_FIRST=1, 0x01 then 0x80 -> sout = 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
- Reset asserted during the 3rd bit of 0xFF -> all outputs 0 in the same cycle; after release the block is idle with sout_valid = 0 and nothing emitted until the next accept.
- DATA_W=12, 0xABC, din_valid pulsed while busy -> bits 101010111100; mid-frame pulses ignored; counter ends at 11 then returns to IDLE.
- SER_PARITY_EN defined, DATA_W=8: 0x07 -> 9th bit = 1; 0x03 -> 9th bit = 0; frames are 9 cycles long.
